// File: rtl/io_stage_if.sv
// Types and handshake bundle between memory, io and writeback stages.
// Zero latency (wiring only); backpressure is carried on io_allow_in / wb_allow_in.
package io_stage_pkg;

    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_LB   = 3'd1;
    localparam logic [2:0] LOAD_LBU  = 3'd2;
    localparam logic [2:0] LOAD_LH   = 3'd3;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_LW   = 3'd5;
    localparam logic [2:0] LOAD_LWL  = 3'd6;
    localparam logic [2:0] LOAD_LWR  = 3'd7;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] bad_vaddr;
        logic        eret;
        logic        mfc0;
        logic        mtc0;
        logic [7:0]  cp0_address;
        logic        tlbp;
        logic        tlbr;
        logic        tlbwi;
        logic        tlb_refill;
    } excp_t;

    typedef struct packed {
        logic [31:0] program_count;
        logic [31:0] final_result;
        logic [31:0] rt_value;
        logic [2:0]  load_op;
        logic [1:0]  address_low;
        logic        request_sent;
        logic        register_file_write_enabled;
        logic [4:0]  register_file_address;
        excp_t       excp;
    } ms_to_io_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] final_result;
        logic [3:0]  register_file_write_strobe;
        logic        register_file_write_enabled;
        logic [4:0]  register_file_address;
        excp_t       excp;
    } io_to_wb_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  write_register;
        logic [3:0]  write_strobe;
        logic [31:0] write_data;
        logic        data_pending;
    } io_fwd_t;

endpackage

interface io_stage_if;
    import io_stage_pkg::*;

    logic        ms_to_io_valid;
    ms_to_io_t   ms_to_io_bus;
    logic        io_allow_in;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_allow_in;
    io_to_wb_t   io_to_wb_bus;
    logic        wb_have_exception_forwards;
    io_fwd_t     io_to_id_back_pass_bus;

    modport master (
        output ms_to_io_valid, ms_to_io_bus, data_data_ok, data_rdata,
               wb_allow_in, wb_have_exception_forwards,
        input  io_allow_in, io_to_wb_bus, io_to_id_back_pass_bus
    );

    modport slave (
        input  ms_to_io_valid, ms_to_io_bus, data_data_ok, data_rdata,
               wb_allow_in, wb_have_exception_forwards,
        output io_allow_in, io_to_wb_bus, io_to_id_back_pass_bus
    );

endinterface

// File: rtl/io_stage.sv
// Load-completion stage: ALU results pass with zero latency, loads finish on data_data_ok.
// Backpressure: a response arriving while wb_allow_in=0 is buffered and io_allow_in drops.
module io_stage
    import io_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    io_stage_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DISCARD} state_t;

    state_t                state, state_nxt;
    logic                  io_valid;
    ms_to_io_t             ms_q;
    logic [DATA_WIDTH-1:0] hold_word, hold_word_nxt;

    logic flush;
    logic io_ready_go;
    logic allow_in;
    logic latch;
    logic slot_free;
    logic resp_free;

    logic [31:0] word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] shl_word;
    logic [31:0] shr_word;
    logic [31:0] result;
    logic [3:0]  strobe;

    function automatic logic [31:0] merge_bytes(input logic [31:0] load_w,
                                                input logic [31:0] keep_w,
                                                input logic [3:0]  sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (load_w & mask) | (keep_w & ~mask);
    endfunction

    assign flush = bus.wb_have_exception_forwards;

    always_comb begin
        io_ready_go = 1'b1;
        case (state)
            S_WAIT:    io_ready_go = bus.data_data_ok;
            S_DISCARD: io_ready_go = 1'b0;
            default:   io_ready_go = 1'b1;
        endcase
    end

    assign allow_in = (state != S_DISCARD) && (!io_valid || (io_ready_go && bus.wb_allow_in));
    // A flushed cycle never captures the incoming instruction: it is being killed upstream too.
    assign latch    = bus.ms_to_io_valid && allow_in && !flush;

    always_comb begin
        state_nxt     = state;
        hold_word_nxt = hold_word;
        slot_free     = 1'b0;
        resp_free     = 1'b1;
        case (state)
            S_IDLE: slot_free = 1'b1;
            S_WAIT: begin
                if (bus.data_data_ok) begin
                    resp_free = 1'b0;
                    if (bus.wb_allow_in) begin
                        slot_free = 1'b1;
                    end else begin
                        state_nxt     = S_HOLD;
                        hold_word_nxt = bus.data_rdata;
                    end
                end
            end
            S_HOLD: begin
                if (bus.wb_allow_in) begin
                    slot_free = 1'b1;
                end
            end
            S_DISCARD: begin
                if (bus.data_data_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // The slot is (or becomes) empty: track the newcomer's request, possibly answered already.
        if (slot_free) begin
            state_nxt = S_IDLE;
            if (latch && bus.ms_to_io_bus.request_sent) begin
                if (bus.data_data_ok && resp_free) begin
                    state_nxt     = S_HOLD;
                    hold_word_nxt = bus.data_rdata;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
        end

        // An outstanding request killed before its response leaves one orphan to swallow.
        if (flush && state != S_DISCARD) begin
            state_nxt = (state == S_WAIT && !bus.data_data_ok) ? S_DISCARD : S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            hold_word <= '0;
            io_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_word <= hold_word_nxt;
            if (flush) begin
                io_valid <= 1'b0;
            end else if (allow_in) begin
                io_valid <= bus.ms_to_io_valid;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ms_q <= '0;
        end else if (latch) begin
            ms_q <= bus.ms_to_io_bus;
        end
    end

    always_comb begin
        word     = (state == S_HOLD) ? hold_word : bus.data_rdata;
        byte_v   = word[{ms_q.address_low, 3'b000} +: 8];
        half_v   = ms_q.address_low[1] ? word[31:16] : word[15:0];
        shl_word = word << {~ms_q.address_low, 3'b000};
        shr_word = word >> {ms_q.address_low, 3'b000};
        result   = ms_q.final_result;
        strobe   = 4'b1111;
        case (ms_q.load_op)
            LOAD_LB:  result = {{24{byte_v[7]}}, byte_v};
            LOAD_LBU: result = {24'd0, byte_v};
            LOAD_LH:  result = {{16{half_v[15]}}, half_v};
            LOAD_LHU: result = {16'd0, half_v};
            LOAD_LW:  result = word;
            LOAD_LWL: begin
                strobe = 4'b1111 << ~ms_q.address_low;
                result = merge_bytes(shl_word, ms_q.rt_value, strobe);
            end
            LOAD_LWR: begin
                strobe = 4'b1111 >> ms_q.address_low;
                result = merge_bytes(shr_word, ms_q.rt_value, strobe);
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.io_allow_in = allow_in;

        bus.io_to_wb_bus                             = '0;
        bus.io_to_wb_bus.valid                       = io_valid && io_ready_go && !flush;
        bus.io_to_wb_bus.program_count               = ms_q.program_count;
        bus.io_to_wb_bus.final_result                = result;
        bus.io_to_wb_bus.register_file_write_strobe  = strobe;
        bus.io_to_wb_bus.register_file_write_enabled = ms_q.register_file_write_enabled;
        bus.io_to_wb_bus.register_file_address       = ms_q.register_file_address;
        bus.io_to_wb_bus.excp                        = ms_q.excp;

        bus.io_to_id_back_pass_bus                = '0;
        bus.io_to_id_back_pass_bus.valid          = io_valid && ms_q.register_file_write_enabled;
        bus.io_to_id_back_pass_bus.write_register = ms_q.register_file_address;
        bus.io_to_id_back_pass_bus.write_strobe   = strobe;
        bus.io_to_id_back_pass_bus.write_data     = result;
        bus.io_to_id_back_pass_bus.data_pending   = io_valid && (ms_q.load_op != LOAD_NONE)
                                                    && ms_q.request_sent && !io_ready_go;
    end

endmodule

// File: tb/tb_io_stage.sv
// Directed bench for io_stage with a transaction-level model checked every falling edge.
module tb_io_stage;
    import io_stage_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    io_stage_if bus();

    io_stage #(.DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction in the stage, its response (if any), and responses owed to killed loads.
    logic        m_valid = 1'b0;
    logic        m_need  = 1'b0;
    logic        m_have  = 1'b0;
    ms_to_io_t   m_ins   = '0;
    logic [31:0] m_data  = '0;
    int          m_orphans = 0;

    function automatic void expect_load(input ms_to_io_t ins, input logic [31:0] w,
                                        output logic [31:0] r, output logic [3:0] s);
        logic [7:0] wbyte [4];
        logic [7:0] rbyte [4];
        int a;
        a = int'(ins.address_low);
        for (int j = 0; j < 4; j++) begin
            wbyte[j] = w[8*j +: 8];
            rbyte[j] = ins.rt_value[8*j +: 8];
        end
        s = 4'hF;
        r = ins.final_result;
        case (ins.load_op)
            LOAD_LB:  r = {{24{wbyte[a][7]}}, wbyte[a]};
            LOAD_LBU: r = {24'h0, wbyte[a]};
            LOAD_LH:  r = (a >= 2) ? {{16{wbyte[3][7]}}, wbyte[3], wbyte[2]}
                                   : {{16{wbyte[1][7]}}, wbyte[1], wbyte[0]};
            LOAD_LHU: r = (a >= 2) ? {16'h0, wbyte[3], wbyte[2]} : {16'h0, wbyte[1], wbyte[0]};
            LOAD_LW:  r = w;
            LOAD_LWL: begin
                for (int j = 0; j < 4; j++) begin
                    if (j >= 3 - a) rbyte[j] = wbyte[j - (3 - a)];
                    else            s[j] = 1'b0;
                end
                r = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
            end
            LOAD_LWR: begin
                for (int j = 0; j < 4; j++) begin
                    if (j <= 3 - a) rbyte[j] = wbyte[j + a];
                    else            s[j] = 1'b0;
                end
                r = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
            end
            default: ;
        endcase
    endfunction

    always @(negedge clock) begin : compare
        logic [31:0] e_res;
        logic [3:0]  e_str;
        logic        e_owner, e_ready, e_allow, e_wbv, e_leave, e_latch, used, dok;
        if (!reset) begin
            m_valid = 1'b0; m_need = 1'b0; m_have = 1'b0; m_orphans = 0;
            chk("reset_allow_in", 64'(bus.io_allow_in), 64'(1'b1));
            chk("reset_wb_valid", 64'(bus.io_to_wb_bus.valid), 64'(1'b0));
            chk("reset_fwd_valid", 64'(bus.io_to_id_back_pass_bus.valid), 64'(1'b0));
        end else begin
            dok     = bus.data_data_ok;
            e_owner = m_valid && m_need && !m_have;
            e_ready = (m_orphans == 0) && (!e_owner || dok);
            e_allow = (m_orphans == 0) && (!m_valid || (e_ready && bus.wb_allow_in));
            e_wbv   = m_valid && e_ready && !bus.wb_have_exception_forwards;
            expect_load(m_ins, m_have ? m_data : bus.data_rdata, e_res, e_str);

            chk("allow_in", 64'(bus.io_allow_in), 64'(e_allow));
            chk("wb_valid", 64'(bus.io_to_wb_bus.valid), 64'(e_wbv));
            if (e_wbv) begin
                chk("wb_result", 64'(bus.io_to_wb_bus.final_result), 64'(e_res));
                chk("wb_strobe", 64'(bus.io_to_wb_bus.register_file_write_strobe), 64'(e_str));
                chk("wb_pc", 64'(bus.io_to_wb_bus.program_count), 64'(m_ins.program_count));
                chk("wb_rf_addr", 64'(bus.io_to_wb_bus.register_file_address),
                    64'(m_ins.register_file_address));
                chk("wb_excp", 64'(bus.io_to_wb_bus.excp), 64'(m_ins.excp));
            end
            chk("fwd_valid", 64'(bus.io_to_id_back_pass_bus.valid),
                64'(m_valid && m_ins.register_file_write_enabled));
            if (m_valid) begin
                chk("fwd_pending", 64'(bus.io_to_id_back_pass_bus.data_pending),
                    64'((m_ins.load_op != LOAD_NONE) && !e_ready));
                chk("fwd_reg", 64'(bus.io_to_id_back_pass_bus.write_register),
                    64'(m_ins.register_file_address));
                if (e_ready) begin
                    chk("fwd_data", 64'(bus.io_to_id_back_pass_bus.write_data), 64'(e_res));
                    chk("fwd_strobe", 64'(bus.io_to_id_back_pass_bus.write_strobe), 64'(e_str));
                end
            end

            // Advance the model across the coming rising edge (inputs are stable until then).
            used = 1'b0;
            if (m_orphans > 0 && dok) begin
                m_orphans--;
                used = 1'b1;
            end
            if (bus.wb_have_exception_forwards) begin
                if (e_owner && !dok) m_orphans++;
                m_valid = 1'b0;
            end else begin
                if (e_owner && dok) begin
                    m_have = 1'b1; m_data = bus.data_rdata; used = 1'b1;
                end
                e_leave = m_valid && e_ready && bus.wb_allow_in;
                if (!m_valid || e_leave) begin
                    e_latch = bus.ms_to_io_valid && e_allow;
                    m_valid = e_latch;
                    if (e_latch) begin
                        m_ins  = bus.ms_to_io_bus;
                        m_need = bus.ms_to_io_bus.request_sent;
                        m_have = 1'b0;
                        if (bus.ms_to_io_bus.request_sent && dok && !used) begin
                            m_have = 1'b1; m_data = bus.data_rdata;
                        end
                    end
                end
            end
        end
    end

    function automatic ms_to_io_t mk(input logic [2:0] op, input logic [1:0] a, input logic req,
                                     input logic [31:0] fr, input logic [31:0] rt,
                                     input logic [4:0] rd);
        ms_to_io_t i;
        i = '0;
        i.program_count               = 32'hBFC0_0000 + {25'd0, rd, 2'b00};
        i.final_result                = fr;
        i.rt_value                    = rt;
        i.load_op                     = op;
        i.address_low                 = a;
        i.request_sent                = req;
        i.register_file_write_enabled = 1'b1;
        i.register_file_address       = rd;
        return i;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input ms_to_io_t i);
        bus.ms_to_io_valid = 1'b1;
        bus.ms_to_io_bus   = i;
    endtask

    logic [2:0]  t_op [7] = '{LOAD_LBU, LOAD_LH, LOAD_LHU, LOAD_LWR, LOAD_LWR, LOAD_LWL, LOAD_LW};
    logic [1:0]  t_a  [7] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd0};
    logic [31:0] t_rd [7] = '{32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234, 32'hAABB_CCDD,
                              32'hAABB_CCDD, 32'hAABB_CCDD, 32'hDEAD_BEEF};
    logic [31:0] t_er [7] = '{32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_1234, 32'h11AA_BBCC,
                              32'h1122_33AA, 32'hAABB_CCDD, 32'hDEAD_BEEF};
    logic [3:0]  t_es [7] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h1, 4'hF, 4'hF};

    initial begin
        ms_to_io_t ex_ins;
        bus.ms_to_io_valid             = 1'b0;
        bus.ms_to_io_bus               = '0;
        bus.data_data_ok               = 1'b0;
        bus.data_rdata                 = '0;
        bus.wb_allow_in                = 1'b1;
        bus.wb_have_exception_forwards = 1'b0;

        #2;
        chk("por_allow_in", 64'(bus.io_allow_in), 64'(1'b1));
        chk("por_wb_valid", 64'(bus.io_to_wb_bus.valid), 64'(1'b0));
        tick();
        reset = 1'b1;
        tick();

        // LB at byte 3, response one cycle after latch
        put(mk(LOAD_LB, 2'd3, 1'b1, 32'h0, 32'h0, 5'd5));
        tick();
        bus.ms_to_io_valid = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80FF_1234;
        @(negedge clock);
        chk("lb_valid", 64'(bus.io_to_wb_bus.valid), 64'(1'b1));
        chk("lb_result", 64'(bus.io_to_wb_bus.final_result), 64'(32'hFFFF_FF80));
        chk("lb_strobe", 64'(bus.io_to_wb_bus.register_file_write_strobe), 64'(4'hF));
        tick();
        bus.data_data_ok = 1'b0;

        // LWL merge with rt_value
        put(mk(LOAD_LWL, 2'd1, 1'b1, 32'h0, 32'h1122_3344, 5'd6));
        tick();
        bus.ms_to_io_valid = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hAABB_CCDD;
        @(negedge clock);
        chk("lwl_result", 64'(bus.io_to_wb_bus.final_result), 64'(32'hCCDD_3344));
        chk("lwl_strobe", 64'(bus.io_to_wb_bus.register_file_write_strobe), 64'(4'hC));
        tick();
        bus.data_data_ok = 1'b0;

        for (int k = 0; k < 7; k++) begin
            put(mk(t_op[k], t_a[k], 1'b1, 32'h0, 32'h1122_3344, 5'(k + 8)));
            tick();
            bus.ms_to_io_valid = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = t_rd[k];
            @(negedge clock);
            chk($sformatf("tbl%0d_result", k), 64'(bus.io_to_wb_bus.final_result), 64'(t_er[k]));
            chk($sformatf("tbl%0d_strobe", k),
                64'(bus.io_to_wb_bus.register_file_write_strobe), 64'(t_es[k]));
            tick();
            bus.data_data_ok = 1'b0;
        end

        // Response in the same cycle as the latch goes straight to the buffer
        put(mk(LOAD_LW, 2'd0, 1'b1, 32'h0, 32'h0, 5'd3));
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1357_9BDF;
        tick();
        bus.ms_to_io_valid = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        @(negedge clock);
        chk("same_cycle_result", 64'(bus.io_to_wb_bus.final_result), 64'(32'h1357_9BDF));
        tick();

        // Writeback stalls across and after the response
        put(mk(LOAD_LW, 2'd0, 1'b1, 32'h0, 32'h0, 5'd9));
        bus.wb_allow_in = 1'b0;
        tick();
        bus.ms_to_io_valid = 1'b0;
        @(negedge clock);
        chk("wait_pending", 64'(bus.io_to_id_back_pass_bus.data_pending), 64'(1'b1));
        chk("wait_allow_in", 64'(bus.io_allow_in), 64'(1'b0));
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        tick();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0BAD_0BAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("hold_allow_in", 64'(bus.io_allow_in), 64'(1'b0));
            chk("hold_result", 64'(bus.io_to_wb_bus.final_result), 64'(32'hDEAD_BEEF));
            tick();
        end
        bus.wb_allow_in = 1'b1;
        @(negedge clock);
        chk("hold_exit_allow", 64'(bus.io_allow_in), 64'(1'b1));
        tick();
        @(negedge clock);
        chk("hold_gone", 64'(bus.io_to_wb_bus.valid), 64'(1'b0));
        tick();

        // Flush while waiting: the late response is swallowed
        put(mk(LOAD_LW, 2'd0, 1'b1, 32'h0, 32'h0, 5'd10));
        tick();
        bus.ms_to_io_valid = 1'b0; bus.wb_have_exception_forwards = 1'b1;
        @(negedge clock);
        tick();
        bus.wb_have_exception_forwards = 1'b0;
        @(negedge clock);
        chk("discard_allow0", 64'(bus.io_allow_in), 64'(1'b0));
        tick();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        chk("discard_allow1", 64'(bus.io_allow_in), 64'(1'b0));
        chk("discard_no_valid", 64'(bus.io_to_wb_bus.valid), 64'(1'b0));
        tick();
        bus.data_data_ok = 1'b0;
        @(negedge clock);
        chk("discard_done", 64'(bus.io_allow_in), 64'(1'b1));

        // Back-to-back ALU results
        put(mk(LOAD_NONE, 2'd0, 1'b0, 32'h1000, 32'h0, 5'd1));
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) put(mk(LOAD_NONE, 2'd0, 1'b0, 32'(32'h1001 + k), 32'h0, 5'(k + 2)));
            else       bus.ms_to_io_valid = 1'b0;
            @(negedge clock);
            chk("alu_allow_in", 64'(bus.io_allow_in), 64'(1'b1));
            chk("alu_result", 64'(bus.io_to_wb_bus.final_result), 64'(32'h1000 + k));
            tick();
        end

        // Exception-tagged load with no request passes through untouched
        ex_ins = mk(LOAD_LW, 2'd1, 1'b0, 32'h0000_1001, 32'h0, 5'd4);
        ex_ins.excp.ex = 1'b1; ex_ins.excp.excode = 5'h04; ex_ins.excp.bad_vaddr = 32'h0000_1001;
        put(ex_ins);
        tick();
        bus.ms_to_io_valid = 1'b0;
        @(negedge clock);
        chk("exc_valid", 64'(bus.io_to_wb_bus.valid), 64'(1'b1));
        chk("exc_code", 64'(bus.io_to_wb_bus.excp.excode), 64'(5'h04));
        chk("exc_badva", 64'(bus.io_to_wb_bus.excp.bad_vaddr), 64'(32'h0000_1001));
        tick();

        // Reset while waiting, stray response after release, then a normal load
        put(mk(LOAD_LW, 2'd0, 1'b1, 32'h0, 32'h0, 5'd11));
        tick();
        bus.ms_to_io_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("midrst_allow_in", 64'(bus.io_allow_in), 64'(1'b1));
        chk("midrst_wb_valid", 64'(bus.io_to_wb_bus.valid), 64'(1'b0));
        chk("midrst_fwd_valid", 64'(bus.io_to_id_back_pass_bus.valid), 64'(1'b0));
        tick();
        reset = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_5555;
        @(negedge clock);
        chk("stray_ignored", 64'(bus.io_to_wb_bus.valid), 64'(1'b0));
        tick();
        bus.data_data_ok = 1'b0;
        put(mk(LOAD_LHU, 2'd2, 1'b1, 32'h0, 32'h0, 5'd12));
        tick();
        bus.ms_to_io_valid = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        chk("post_rst_valid", 64'(bus.io_to_wb_bus.valid), 64'(1'b1));
        chk("post_rst_result", 64'(bus.io_to_wb_bus.final_result), 64'(32'h0000_CAFE));
        tick();
        bus.data_data_ok = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_stage.md
IO_STAGE -- requirements
Module: io_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, CPU data width; only 32 SHALL be supported.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous reset, active-low (asserted at 0), synchronous release assumed by upstream.
REQ-004 ms_to_io_valid  input  1  memory-stage instruction valid.
REQ-005 ms_to_io_bus  input  struct  program_count, final_result[31:0], rt_value[31:0], load_op[2:0], address_low[1:0], request_sent, register_file_write_enabled, register_file_address[4:0], exception/cp0/tlb fields.
REQ-006 io_allow_in  output  1  stage can accept ms_to_io_bus this cycle.
REQ-007 data_data_ok  input  1  data-SRAM response strobe, one per sent request, in order.
REQ-008 data_rdata  input  32  response word, valid with data_data_ok.
REQ-009 wb_allow_in  input  1  writeback stage acceptance.
REQ-010 io_to_wb_bus  output  struct  valid, final_result, register_file_write_strobe[3:0], remaining fields copied from latched ms_to_io_bus.
REQ-011 wb_have_exception_forwards  input  1  flush: exception or eret in writeback.
REQ-012 io_to_id_back_pass_bus  output  struct  valid, write_register[4:0], write_strobe[3:0], write_data[31:0], data_pending (forward not yet usable).

Function
REQ-013 Stage SHALL hold io_valid and a latched copy of ms_to_io_bus; latch SHALL occur when ms_to_io_valid && io_allow_in.
REQ-014 io_allow_in SHALL equal !io_valid || (io_ready_go && wb_allow_in), and SHALL be 0 in DISCARD.
REQ-015 Response FSM states: IDLE, WAIT (request_sent, no data), HOLD (data buffered), DISCARD (drop one orphan response).
REQ-016 IDLE->WAIT on latch with request_sent=1 and no data_data_ok that cycle; same-cycle data_data_ok SHALL go directly to HOLD or pass through.
REQ-017 WAIT->HOLD on data_data_ok when the instruction cannot leave; WAIT->IDLE when data_data_ok and leaving same cycle.
REQ-018 HOLD->IDLE when instruction leaves (io_valid && wb_allow_in).
REQ-019 io_ready_go SHALL be 1 in IDLE, 1 in HOLD, equal to data_data_ok in WAIT, 0 in DISCARD.
REQ-020 io_to_wb_bus.valid SHALL equal io_valid && io_ready_go && !wb_have_exception_forwards.
REQ-021 Load data source SHALL be data_rdata in WAIT, buffered word in HOLD.
REQ-022 load_op encoding: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR; LB/LH sign-extend, LBU/LHU zero-extend, selecting byte/half by address_low.
REQ-023 LWL SHALL merge word<<(8*(3-address_low)) with rt_value, strobe = 4'b1111<<(3-address_low); LWR SHALL shift word>>(8*address_low), strobe = 4'b1111>>address_low.
REQ-024 Non-load instructions SHALL pass final_result and strobe 4'b1111 unchanged with zero latency.
REQ-025 Forward bus valid SHALL be io_valid && register_file_write_enabled; data_pending SHALL be 1 when io_valid, load_op!=0 and !io_ready_go.
REQ-026 Flush (wb_have_exception_forwards=1) SHALL clear io_valid next edge; if state is WAIT and data_data_ok absent, FSM SHALL enter DISCARD, else IDLE.
REQ-027 DISCARD SHALL consume exactly one data_data_ok without forwarding it, then go to IDLE.
REQ-028 Misaligned-address or TLB exceptions on latched bus SHALL not change FSM (request_sent=0 upstream); exception fields SHALL be forwarded unchanged.

Reset
REQ-029 On reset=0, io_valid SHALL be 0, FSM IDLE, HOLD buffer 0, io_to_wb_bus.valid 0, forward valid 0, io_allow_in 1 asynchronously.
REQ-030 Reset mid-WAIT SHALL abandon the request; stray data_data_ok after release in IDLE SHALL be ignored.

Verification
REQ-031 LB, address_low=3, data_rdata=0x80FF_1234 one cycle after latch -> final_result 0xFFFF_FF80, strobe 4'b1111, valid 1 cycle later.
REQ-032 LWL, address_low=1, rt_value=0x1122_3344, rdata=0xAABB_CCDD -> result 0xCCDD_3344, strobe 4'b1100.
REQ-033 data_data_ok while wb_allow_in=0 for 3 cycles -> HOLD, io_allow_in 0, result stable, exit on wb_allow_in=1.
REQ-034 Flush in WAIT, data_data_ok 2 cycles later -> DISCARD, no io_to_wb valid, io_allow_in 0 until response, then 1.
REQ-035 Back-to-back ALU ops with wb_allow_in=1 -> one result per cycle, io_allow_in constantly 1.
REQ-036 reset=0 asserted mid-WAIT -> all outputs reset values immediately, next instruction after release completes normally.
